latch_bank_write_sequencer: RTL and testbench

- Sequences and arbitrates writes into a bank of DEPTH x DW active-low-reset transparent latches (LARX-style cells: D, CLK enable, RSTB clear).
- Shares the bank between N_REQ requesters using round-robin arbitration.
- Generates glitch-free, registered, one-hot latch enables, with guaranteed data setup and hold cycles around each enable pulse.
- Also sequences a bank-wide clear through the latches' shared RSTB net.

---
 rtl/latch_seq_pkg.sv | 25 ++
 rtl/rr_arbiter.sv | 28 ++
 rtl/latch_bank_write_sequencer.sv | 170 +++++++++++++++++
 tb/tb_latch_bank_write_sequencer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/latch_seq_pkg.sv
// Shared types and helpers for the latch bank write sequencer.
// Holds the FSM state encoding and the counter sizing used by the top and its arbiter.
package latch_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        CLEAR
    } seq_state_t;

    // Phase counters hold SETUP_CYC-1, HOLD_CYC-1 or CLR_CYC-1, so each phase length must stay below 2**PHASE_W.
    localparam int PHASE_W = 8;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first set request at or above ptr, wrapping.
// The caller registers the grant.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant
);

    logic found;

    // Walk offsets from the pointer; the inner loop keeps every index a loop constant.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int off = 0; off < N; off++) begin
            for (int j = 0; j < N; j++) begin
                if (!found && req[j] && (j == ((int'(ptr) + off) % N))) begin
                    grant[j] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/latch_bank_write_sequencer.sv
// Arbitrates writes from N_REQ requesters into a bank of transparent latches and sequences
// bank clears; every latch-facing output comes straight from a flop.
module latch_bank_write_sequencer
    import latch_seq_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int DEPTH     = 8,
    parameter int DW        = 8,
    parameter int AW        = 3,
    parameter int SETUP_CYC = 1,
    parameter int HOLD_CYC  = 1,
    parameter int CLR_CYC   = 2
) (
    input  logic                CLK,
    input  logic                RSTB,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*AW-1:0] req_addr,
    input  logic [N_REQ*DW-1:0] req_data,
    output logic [N_REQ-1:0]    ack,
    output logic                wr_err,
    input  logic                clr_req,
    output logic                clr_done,
    output logic [DEPTH-1:0]    lat_en,
    output logic [DW-1:0]       lat_d,
    output logic                lat_rstb,
    output logic                busy
);

    localparam int PTR_W = (clog2(N_REQ) > 0) ? clog2(N_REQ) : 1;
    localparam logic [PHASE_W-1:0] SETUP_LOAD = PHASE_W'(SETUP_CYC - 1);
    localparam logic [PHASE_W-1:0] HOLD_LOAD  = PHASE_W'(HOLD_CYC - 1);
    localparam logic [PHASE_W-1:0] CLR_LOAD   = PHASE_W'(CLR_CYC - 1);

    seq_state_t         state_q, state_n;
    logic [PHASE_W-1:0] cnt_q, cnt_n;
    logic [PTR_W-1:0]   ptr_q, ptr_n;
    logic [PTR_W-1:0]   gidx_q, gidx_n;
    logic [N_REQ-1:0]   grant_q, grant_n;
    logic [N_REQ-1:0]   arb_grant;
    logic [AW-1:0]      addr_q, addr_n;
    logic [DW-1:0]      d_n;
    logic               pend_q, pend_n;
    logic               addr_ok;
    logic               last_n;
    logic [DEPTH-1:0]   en_n;
    logic [N_REQ-1:0]   ack_n;
    logic               err_n, done_n, rstb_n, busy_n;

    rr_arbiter #(
        .N  (N_REQ),
        .PW (PTR_W)
    ) u_arb (
        .req   (req),
        .ptr   (ptr_q),
        .grant (arb_grant)
    );

    assign addr_ok = int'(addr_q) < DEPTH;

    // Next-state logic; outputs are derived from the next state so they can be registered.
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        ptr_n   = ptr_q;
        gidx_n  = gidx_q;
        grant_n = grant_q;
        addr_n  = addr_q;
        d_n     = lat_d;
        pend_n  = pend_q | clr_req;

        case (state_q)
            IDLE: begin
                if (pend_q || clr_req) begin
                    state_n = CLEAR;
                    cnt_n   = CLR_LOAD;
                    pend_n  = 1'b0;
                end else if (|req) begin
                    state_n = SETUP;
                    cnt_n   = SETUP_LOAD;
                    grant_n = arb_grant;
                    for (int j = 0; j < N_REQ; j++) begin
                        if (arb_grant[j]) begin
                            gidx_n = PTR_W'(j);
                            addr_n = req_addr[j*AW +: AW];
                            d_n    = req_data[j*DW +: DW];
                        end
                    end
                end
            end
            SETUP: begin
                if (cnt_q == '0) begin
                    state_n = PULSE;
                end else begin
                    cnt_n = cnt_q - 1'b1;
                end
            end
            PULSE: begin
                state_n = HOLD;
                cnt_n   = HOLD_LOAD;
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    state_n = IDLE;
                    ptr_n   = PTR_W'((int'(gidx_q) + 1) % N_REQ);
                end else begin
                    cnt_n = cnt_q - 1'b1;
                end
            end
            CLEAR: begin
                if (cnt_q == '0) begin
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt_q - 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        last_n = (cnt_n == '0);
        en_n   = '0;
        for (int w = 0; w < DEPTH; w++) begin
            if ((state_n == PULSE) && (int'(addr_q) == w)) begin
                en_n[w] = 1'b1;
            end
        end
        ack_n  = ((state_n == HOLD) && last_n) ? grant_q : '0;
        err_n  = (state_n == HOLD) && last_n && !addr_ok;
        done_n = (state_n == CLEAR) && last_n;
        rstb_n = (state_n != CLEAR);
        busy_n = (state_n != IDLE);
    end

    // Reset holds the bank cleared; lat_rstb rises on the first edge after release.
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            ptr_q    <= '0;
            gidx_q   <= '0;
            grant_q  <= '0;
            addr_q   <= '0;
            pend_q   <= 1'b0;
            lat_d    <= '0;
            lat_en   <= '0;
            ack      <= '0;
            wr_err   <= 1'b0;
            clr_done <= 1'b0;
            lat_rstb <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state_q  <= state_n;
            cnt_q    <= cnt_n;
            ptr_q    <= ptr_n;
            gidx_q   <= gidx_n;
            grant_q  <= grant_n;
            addr_q   <= addr_n;
            pend_q   <= pend_n;
            lat_d    <= d_n;
            lat_en   <= en_n;
            ack      <= ack_n;
            wr_err   <= err_n;
            clr_done <= done_n;
            lat_rstb <= rstb_n;
            busy     <= busy_n;
        end
    end

endmodule

// File: tb/tb_latch_bank_write_sequencer.sv
// Self-checking bench for latch_bank_write_sequencer (DEPTH=6 so address 7 is out of range).
// Table-driven vectors plus hand-written multi-cycle sequences and random invariant checks.
module tb_latch_bank_write_sequencer;

    localparam int N_REQ = 4;
    localparam int DEPTH = 6;
    localparam int DW    = 8;
    localparam int AW    = 3;

    logic                CLK = 1'b0;
    logic                RSTB;
    logic [N_REQ-1:0]    req;
    logic [N_REQ*AW-1:0] req_addr;
    logic [N_REQ*DW-1:0] req_data;
    logic [N_REQ-1:0]    ack;
    logic                wr_err;
    logic                clr_req;
    logic                clr_done;
    logic [DEPTH-1:0]    lat_en;
    logic [DW-1:0]       lat_d;
    logic                lat_rstb;
    logic                busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    latch_bank_write_sequencer #(
        .N_REQ (N_REQ),
        .DEPTH (DEPTH),
        .DW    (DW),
        .AW    (AW)
    ) dut (
        .CLK      (CLK),
        .RSTB     (RSTB),
        .req      (req),
        .req_addr (req_addr),
        .req_data (req_data),
        .ack      (ack),
        .wr_err   (wr_err),
        .clr_req  (clr_req),
        .clr_done (clr_done),
        .lat_en   (lat_en),
        .lat_d    (lat_d),
        .lat_rstb (lat_rstb),
        .busy     (busy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0]  req;
        logic [11:0] addr;
        logic [31:0] data;
        logic        clr;
        logic [5:0]  en;
        logic [7:0]  d;
        logic [3:0]  ack;
        logic        err;
        logic        rstb;
        logic        done;
        logic        busy;
    } vec_t;

    vec_t vecs[15];

    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic [11:0] a,
                                 input logic [31:0] d, input logic c);
        req      = r;
        req_addr = a;
        req_data = d;
        clr_req  = c;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    initial begin
        int g;
        int n;
        int last_pulse;
        logic [7:0] prev_d;
        logic       prev_busy;

        // Test 1: req[2] addr 5 data A5
        vecs[0]  = '{4'h4, 12'h140, 32'h00A50000, 1'b0, 6'h00, 8'hA5, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[1]  = '{4'h4, 12'h140, 32'h00A50000, 1'b0, 6'h20, 8'hA5, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[2]  = '{4'h4, 12'h140, 32'h00A50000, 1'b0, 6'h00, 8'hA5, 4'h4, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[3]  = '{4'h0, 12'h140, 32'h00A50000, 1'b0, 6'h00, 8'hA5, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0};
        // Test 3: req[0] addr 7 (out of range) data 3C
        vecs[4]  = '{4'h1, 12'h007, 32'h0000003C, 1'b0, 6'h00, 8'h3C, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[5]  = '{4'h1, 12'h007, 32'h0000003C, 1'b0, 6'h00, 8'h3C, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[6]  = '{4'h1, 12'h007, 32'h0000003C, 1'b0, 6'h00, 8'h3C, 4'h1, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[7]  = '{4'h0, 12'h007, 32'h0000003C, 1'b0, 6'h00, 8'h3C, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0};
        // Clear and req[1] together in IDLE: clear first, then the write
        vecs[8]  = '{4'h2, 12'h008, 32'h00004400, 1'b1, 6'h00, 8'h3C, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{4'h2, 12'h008, 32'h00004400, 1'b0, 6'h00, 8'h3C, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[10] = '{4'h2, 12'h008, 32'h00004400, 1'b0, 6'h00, 8'h3C, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{4'h2, 12'h008, 32'h00004400, 1'b0, 6'h00, 8'h44, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[12] = '{4'h2, 12'h008, 32'h00004400, 1'b0, 6'h02, 8'h44, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[13] = '{4'h2, 12'h008, 32'h00004400, 1'b0, 6'h00, 8'h44, 4'h2, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[14] = '{4'h0, 12'h008, 32'h00004400, 1'b0, 6'h00, 8'h44, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0};

        RSTB = 1'b0;
        applyStimulus(4'h0, 12'h000, 32'h0, 1'b0);
        tick();
        tick();
        checkOutput("rst_lat_en", 32'(lat_en), 32'h0);
        checkOutput("rst_lat_rstb", 32'(lat_rstb), 32'h0);
        checkOutput("rst_ack", 32'(ack), 32'h0);
        checkOutput("rst_busy", 32'(busy), 32'h0);
        checkOutput("rst_lat_d", 32'(lat_d), 32'h0);
        checkOutput("rst_wr_err", 32'(wr_err), 32'h0);
        checkOutput("rst_clr_done", 32'(clr_done), 32'h0);
        RSTB = 1'b1;
        tick();
        checkOutput("rel_lat_rstb", 32'(lat_rstb), 32'h1);
        checkOutput("rel_busy", 32'(busy), 32'h0);

        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].req, vecs[i].addr, vecs[i].data, vecs[i].clr);
            tick();
            checkOutput($sformatf("row%0d_lat_en", i), 32'(lat_en), 32'(vecs[i].en));
            checkOutput($sformatf("row%0d_lat_d", i), 32'(lat_d), 32'(vecs[i].d));
            checkOutput($sformatf("row%0d_ack", i), 32'(ack), 32'(vecs[i].ack));
            checkOutput($sformatf("row%0d_wr_err", i), 32'(wr_err), 32'(vecs[i].err));
            checkOutput($sformatf("row%0d_lat_rstb", i), 32'(lat_rstb), 32'(vecs[i].rstb));
            checkOutput($sformatf("row%0d_clr_done", i), 32'(clr_done), 32'(vecs[i].done));
            checkOutput($sformatf("row%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
        end

        // Test 5: reset asserted during SETUP
        applyStimulus(4'h1, 12'h002, 32'h0000005A, 1'b0);
        tick();
        checkOutput("t5_setup_busy", 32'(busy), 32'h1);
        checkOutput("t5_setup_lat_d", 32'(lat_d), 32'h5A);
        RSTB = 1'b0;
        req  = 4'h0;
        #1;
        checkOutput("t5_rst_lat_en", 32'(lat_en), 32'h0);
        checkOutput("t5_rst_lat_rstb", 32'(lat_rstb), 32'h0);
        checkOutput("t5_rst_ack", 32'(ack), 32'h0);
        checkOutput("t5_rst_busy", 32'(busy), 32'h0);
        tick();
        RSTB = 1'b1;
        checkOutput("t5_held_lat_rstb", 32'(lat_rstb), 32'h0);
        tick();
        checkOutput("t5_rel_lat_rstb", 32'(lat_rstb), 32'h1);
        checkOutput("t5_rel_busy", 32'(busy), 32'h0);

        // Test 2: round-robin from a freshly reset pointer
        applyStimulus(4'hF, 12'b011_010_001_000, 32'h13121110, 1'b0);
        last_pulse = 0;
        for (int k = 0; k < 5; k++) begin
            g = k % 4;
            n = 0;
            while (lat_en == '0 && n < 10) begin
                tick();
                n++;
            end
            if (lat_en == '0) begin
                checkOutput($sformatf("rr%0d_timeout", k), 32'(lat_en), 32'(1 << g));
            end else begin
                checkOutput($sformatf("rr%0d_lat_en", k), 32'(lat_en), 32'(1 << g));
                checkOutput($sformatf("rr%0d_lat_d", k), 32'(lat_d), 32'h10 + 32'(g));
                if (k > 0) begin
                    checkOutput($sformatf("rr%0d_spacing", k), 32'(cyc - last_pulse), 32'd4);
                end
                last_pulse = cyc;
            end
            tick();
            checkOutput($sformatf("rr%0d_ack", k), 32'(ack), 32'(1 << g));
            if (k == 4) req = 4'h0;
            else req[g] = 1'b0;
            tick();
            checkOutput($sformatf("rr%0d_ack_end", k), 32'(ack), 32'h0);
            if (k < 4) req[g] = 1'b1;
        end

        // Test 4: clear pulsed during PULSE of a write, req[1] waiting behind it
        applyStimulus(4'h1, 12'h02C, 32'h00007711, 1'b0);
        tick();
        checkOutput("t4_setup_lat_d", 32'(lat_d), 32'h11);
        tick();
        checkOutput("t4_pulse_lat_en", 32'(lat_en), 32'h10);
        clr_req = 1'b1;
        req     = 4'h3;
        tick();
        checkOutput("t4_hold_ack", 32'(ack), 32'h1);
        checkOutput("t4_hold_lat_rstb", 32'(lat_rstb), 32'h1);
        clr_req = 1'b0;
        req     = 4'h2;
        tick();
        checkOutput("t4_idle_busy", 32'(busy), 32'h0);
        checkOutput("t4_idle_lat_rstb", 32'(lat_rstb), 32'h1);
        tick();
        checkOutput("t4_clr1_lat_rstb", 32'(lat_rstb), 32'h0);
        checkOutput("t4_clr1_clr_done", 32'(clr_done), 32'h0);
        checkOutput("t4_clr1_lat_en", 32'(lat_en), 32'h0);
        tick();
        checkOutput("t4_clr2_lat_rstb", 32'(lat_rstb), 32'h0);
        checkOutput("t4_clr2_clr_done", 32'(clr_done), 32'h1);
        tick();
        checkOutput("t4_exit_lat_rstb", 32'(lat_rstb), 32'h1);
        checkOutput("t4_exit_busy", 32'(busy), 32'h0);
        tick();
        checkOutput("t4_grant1_lat_d", 32'(lat_d), 32'h77);
        tick();
        checkOutput("t4_grant1_lat_en", 32'(lat_en), 32'h20);
        tick();
        checkOutput("t4_grant1_ack", 32'(ack), 32'h2);
        req = 4'h0;
        tick();

        // Test 6: random stimulus, invariants every cycle
        for (int c = 0; c < 10000; c++) begin
            applyStimulus(4'($urandom_range(0, 15)), 12'($urandom), $urandom,
                          ($urandom_range(0, 19) == 0));
            prev_d    = lat_d;
            prev_busy = busy;
            tick();
            checkOutput("inv_onehot", 32'($onehot0(lat_en)), 32'h1);
            checkOutput("inv_en_vs_clear", 32'((|lat_en) && !lat_rstb), 32'h0);
            if (lat_d != prev_d) begin
                checkOutput("inv_lat_d_change", 32'(!prev_busy && busy), 32'h1);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
